// File: rtl/sys_mode_pkg.sv
// Shared state encodings, key masks and key decode helper for the system-mode controller.
package sys_mode_pkg;

    typedef enum logic [2:0] {
        ST_INIT        = 3'd0,
        ST_NORM        = 3'd1,
        ST_TUNESEL     = 3'd2,
        ST_TUNING      = 3'd3,
        ST_ALARMSEL    = 3'd4,
        ST_ALARMTUNING = 3'd5,
        ST_ALARMING    = 3'd6
    } state_e;

    localparam logic [3:0] K_CONFIRM = 4'b1000;
    localparam logic [3:0] K_UP      = 4'b0100;
    localparam logic [3:0] K_DOWN    = 4'b0010;
    localparam logic [3:0] K_CANCEL  = 4'b0001;

    // A key press counts only when exactly one key line is active.
    function automatic logic key_valid(input logic [3:0] k);
        return (k != 4'b0000) && ((k & (k - 4'd1)) == 4'b0000);
    endfunction

endpackage

// File: rtl/sys_tick_timer.sv
// Counts tick pulses and flags the LIMIT-th tick since the last clear; clr dominates tick.
module sys_tick_timer #(
    parameter int unsigned LIMIT = 30
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic tick,
    output logic expire
);

    localparam int unsigned CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign expire = tick & ~clr & (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (tick) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/sys_mode_ctrl.sv
// Clock system-mode controller: key/alarm decode into mode, tuning strobes, pending queue and ringer.
// Optional snooze on UP while ringing is built when SYS_MODE_SNOOZE_EN is defined.
module sys_mode_ctrl
    import sys_mode_pkg::*;
#(
    parameter int N_ALARMS      = 2,
    parameter int N_FIELDS      = 3,
    parameter int TIMEOUT_TICKS = 30,
    parameter int RING_TICKS    = 60,
    parameter int SNOOZE_TICKS  = 300,
    localparam int FSEL_W = (N_FIELDS > 1) ? $clog2(N_FIELDS) : 1,
    localparam int ASEL_W = (N_ALARMS > 1) ? $clog2(N_ALARMS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [3:0]          neg_keys_filtered,
    input  logic                tick_1hz,
    input  logic [N_ALARMS-1:0] alarm_hit,
    input  logic [N_ALARMS-1:0] alarm_en,
    output logic [2:0]          sys_status,
    output logic [FSEL_W-1:0]   field_sel,
    output logic [ASEL_W-1:0]   alarm_sel,
    output logic                ring,
    output logic [ASEL_W-1:0]   ring_idx,
    output logic                tune_inc,
    output logic                tune_dec,
    output logic [N_ALARMS-1:0] pending
);

    localparam logic [N_ALARMS-1:0] ONE_A = 1;
    localparam logic [FSEL_W-1:0]   F_MAX = FSEL_W'(N_FIELDS - 1);
    localparam logic [ASEL_W-1:0]   A_MAX = ASEL_W'(N_ALARMS - 1);

    state_e                state_q, state_d;
    logic [FSEL_W-1:0]     field_sel_q, field_sel_d;
    logic [ASEL_W-1:0]     alarm_sel_q, alarm_sel_d;
    logic [ASEL_W-1:0]     ring_idx_q, ring_idx_d;
    logic                  tune_inc_q, tune_inc_d;
    logic                  tune_dec_q, tune_dec_d;
    logic                  ring_q;
    logic [N_ALARMS-1:0]   pending_q, pending_d;
    logic [N_ALARMS-1:0]   service_mask, set_mask, snz_set;
    logic [ASEL_W-1:0]     pend_idx;
    logic                  key_vld, k_confirm, k_up, k_down, k_cancel;
    logic                  in_sel_state, to_expire, ring_expire;

    assign key_vld   = key_valid(neg_keys_filtered);
    assign k_confirm = (neg_keys_filtered == K_CONFIRM);
    assign k_up      = (neg_keys_filtered == K_UP);
    assign k_down    = (neg_keys_filtered == K_DOWN);
    assign k_cancel  = (neg_keys_filtered == K_CANCEL);

    assign in_sel_state = (state_q == ST_TUNESEL) || (state_q == ST_TUNING) ||
                          (state_q == ST_ALARMSEL) || (state_q == ST_ALARMTUNING);

    // Every entry into states 2..5 is caused by a valid key, so clearing on key covers entry.
    sys_tick_timer #(.LIMIT(TIMEOUT_TICKS)) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .clr    (key_vld | ~in_sel_state),
        .tick   (tick_1hz),
        .expire (to_expire)
    );

    sys_tick_timer #(.LIMIT(RING_TICKS)) u_ring (
        .clk    (clk),
        .rst    (rst),
        .clr    (state_q != ST_ALARMING),
        .tick   (tick_1hz),
        .expire (ring_expire)
    );

`ifdef SYS_MODE_SNOOZE_EN
    logic              snooze_go, snz_armed_q, snz_expire;
    logic [ASEL_W-1:0] snz_idx_q;

    sys_tick_timer #(.LIMIT(SNOOZE_TICKS)) u_snooze (
        .clk    (clk),
        .rst    (rst),
        .clr    (snooze_go | ~snz_armed_q),
        .tick   (tick_1hz & snz_armed_q),
        .expire (snz_expire)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            snz_armed_q <= 1'b0;
            snz_idx_q   <= '0;
        end else if (snooze_go) begin
            snz_armed_q <= 1'b1;
            snz_idx_q   <= ring_idx_q;
        end else if (snz_expire) begin
            snz_armed_q <= 1'b0;
        end
    end

    assign snz_set = snz_expire ? (ONE_A << snz_idx_q) : '0;
`else
    assign snz_set = '0;
`endif

    always_comb begin
        pend_idx = '0;
        for (int i = N_ALARMS - 1; i >= 0; i--) begin
            if (pending_q[i]) pend_idx = ASEL_W'(i);
        end
    end

    always_comb begin
        state_d      = state_q;
        field_sel_d  = field_sel_q;
        alarm_sel_d  = alarm_sel_q;
        ring_idx_d   = ring_idx_q;
        tune_inc_d   = 1'b0;
        tune_dec_d   = 1'b0;
        service_mask = '0;
`ifdef SYS_MODE_SNOOZE_EN
        snooze_go    = 1'b0;
`endif
        case (state_q)
            ST_INIT: begin
                if (neg_keys_filtered == 4'b0000) state_d = ST_NORM;
            end
            ST_NORM: begin
                if (k_confirm) begin
                    state_d     = ST_TUNESEL;
                    field_sel_d = '0;
                end else if (k_cancel) begin
                    state_d = ST_ALARMSEL;
                end else if (pending_q != '0) begin
                    state_d      = ST_ALARMING;
                    ring_idx_d   = pend_idx;
                    service_mask = ONE_A << pend_idx;
                end
            end
            ST_TUNESEL: begin
                if (k_up)           field_sel_d = (field_sel_q == F_MAX) ? '0 : field_sel_q + 1'b1;
                else if (k_down)    field_sel_d = (field_sel_q == '0) ? F_MAX : field_sel_q - 1'b1;
                else if (k_confirm) state_d = ST_TUNING;
                else if (k_cancel)  state_d = ST_NORM;
                else if (to_expire) state_d = ST_NORM;
            end
            ST_TUNING, ST_ALARMTUNING: begin
                if (k_up)                        tune_inc_d = 1'b1;
                else if (k_down)                 tune_dec_d = 1'b1;
                else if (k_confirm || k_cancel)  state_d = (state_q == ST_TUNING) ? ST_TUNESEL : ST_ALARMSEL;
                else if (to_expire)              state_d = ST_NORM;
            end
            ST_ALARMSEL: begin
                if (k_up)           alarm_sel_d = (alarm_sel_q == A_MAX) ? '0 : alarm_sel_q + 1'b1;
                else if (k_down)    alarm_sel_d = (alarm_sel_q == '0) ? A_MAX : alarm_sel_q - 1'b1;
                else if (k_confirm) state_d = ST_ALARMTUNING;
                else if (k_cancel)  state_d = ST_NORM;
                else if (to_expire) state_d = ST_NORM;
            end
            ST_ALARMING: begin
`ifdef SYS_MODE_SNOOZE_EN
                if (k_up) snooze_go = 1'b1;
`endif
                if (key_vld || ring_expire) state_d = ST_NORM;
            end
            default: state_d = ST_NORM;
        endcase
    end

    // A repeat hit on the channel already ringing is absorbed; new sets beat en-clear and service.
    always_comb begin
        set_mask = alarm_hit & alarm_en;
        if (state_q == ST_ALARMING) set_mask = set_mask & ~(ONE_A << ring_idx_q);
        pending_d = (pending_q & alarm_en & ~service_mask) | set_mask | snz_set;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_INIT;
            field_sel_q <= '0;
            alarm_sel_q <= '0;
            ring_idx_q  <= '0;
            tune_inc_q  <= 1'b0;
            tune_dec_q  <= 1'b0;
            ring_q      <= 1'b0;
            pending_q   <= '0;
        end else begin
            state_q     <= state_d;
            field_sel_q <= field_sel_d;
            alarm_sel_q <= alarm_sel_d;
            ring_idx_q  <= ring_idx_d;
            tune_inc_q  <= tune_inc_d;
            tune_dec_q  <= tune_dec_d;
            ring_q      <= (state_d == ST_ALARMING);
            pending_q   <= pending_d;
        end
    end

    assign sys_status = state_q;
    assign field_sel  = field_sel_q;
    assign alarm_sel  = alarm_sel_q;
    assign ring       = ring_q;
    assign ring_idx   = ring_idx_q;
    assign tune_inc   = tune_inc_q;
    assign tune_dec   = tune_dec_q;
    assign pending    = pending_q;

endmodule

// File: tb/tb_sys_mode_ctrl.sv
// Directed bench for sys_mode_ctrl with default parameters (2 alarms, 3 fields, 30/60/300 ticks).
module tb_sys_mode_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] keys;
    logic       tick;
    logic [1:0] hit, en;
    logic [2:0] sys_status;
    logic [1:0] field_sel;
    logic       alarm_sel, ring, ring_idx, tune_inc, tune_dec;
    logic [1:0] pending;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sys_mode_ctrl dut (
        .clk               (clk),
        .rst               (rst),
        .neg_keys_filtered (keys),
        .tick_1hz          (tick),
        .alarm_hit         (hit),
        .alarm_en          (en),
        .sys_status        (sys_status),
        .field_sel         (field_sel),
        .alarm_sel         (alarm_sel),
        .ring              (ring),
        .ring_idx          (ring_idx),
        .tune_inc          (tune_inc),
        .tune_dec          (tune_dec),
        .pending           (pending)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic key(input logic [3:0] k);
        keys = k;
        cyc();
        keys = 4'b0000;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            tick = 1'b1;
            cyc();
        end
        tick = 1'b0;
    endtask

    task automatic alarm(input logic [1:0] h);
        hit = h;
        cyc();
        hit = 2'b00;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; keys = 4'b0000; tick = 1'b0; hit = 2'b00; en = 2'b11;
        cyc(); cyc();
        chk("rst_status", sys_status, 0);
        chk("rst_field", field_sel, 0);
        chk("rst_asel", alarm_sel, 0);
        chk("rst_ring", ring, 0);
        chk("rst_ridx", ring_idx, 0);
        chk("rst_inc", tune_inc, 0);
        chk("rst_dec", tune_dec, 0);
        chk("rst_pend", pending, 0);

        rst = 1'b0; keys = 4'b1000;
        cyc();
        chk("init_hold", sys_status, 0);
        keys = 4'b0000;
        cyc();
        chk("init_norm", sys_status, 1);

        key(4'b1000);
        chk("tunesel", sys_status, 2);
        chk("field0", field_sel, 0);
        key(4'b0010);
        chk("field_wrap", field_sel, 2);
        key(4'b0100);
        chk("field_up_wrap", field_sel, 0);
        key(4'b0100);
        chk("field_up", field_sel, 1);
        key(4'b1000);
        chk("tuning", sys_status, 3);
        key(4'b0100);
        chk("inc_pulse", tune_inc, 1);
        chk("inc_nodec", tune_dec, 0);
        cyc();
        chk("inc_single", tune_inc, 0);
        key(4'b0010);
        chk("dec_pulse", tune_dec, 1);

        alarm(2'b11);
        chk("pend_both", pending, 2'b11);
        key(4'b0001);
        chk("back_tunesel", sys_status, 2);
        key(4'b0001);
        chk("back_norm", sys_status, 1);
        chk("pend_held", pending, 2'b11);
        cyc();
        chk("ring0_state", sys_status, 6);
        chk("ring0_idx", ring_idx, 0);
        chk("ring0_on", ring, 1);
        chk("ring0_pend", pending, 2'b10);
        key(4'b1000);
        chk("dismiss0", sys_status, 1);
        chk("dismiss0_ring", ring, 0);
        cyc();
        chk("ring1_state", sys_status, 6);
        chk("ring1_idx", ring_idx, 1);
        chk("ring1_pend", pending, 0);

        alarm(2'b10);
        chk("self_hit_drop", pending, 0);
        alarm(2'b01);
        chk("hit_while_ring", pending, 2'b01);
        key(4'b1001);
        chk("multikey_noop", sys_status, 6);
        ticks(59);
        chk("ring_59", sys_status, 6);
        ticks(1);
        chk("ring_stop", sys_status, 1);
        chk("ring_stop_ring", ring, 0);
        cyc();
        chk("ring0b_state", sys_status, 6);
        chk("ring0b_idx", ring_idx, 0);
        chk("ring0b_pend", pending, 0);
        key(4'b0010);
        chk("dismiss_down", sys_status, 1);

        key(4'b1000);
        alarm(2'b01);
        chk("pend_sel", pending, 2'b01);
        en = 2'b10;
        cyc();
        chk("en_clear", pending, 0);
        alarm(2'b01);
        chk("disabled_hit", pending, 0);
        en = 2'b11;
        key(4'b0001);
        chk("sel_cancel", sys_status, 1);

        key(4'b0001);
        chk("alarmsel", sys_status, 4);
        key(4'b0010);
        chk("asel_wrap", alarm_sel, 1);
        ticks(29);
        chk("to_29", sys_status, 4);
        key(4'b0100);
        chk("asel_up", alarm_sel, 0);
        ticks(29);
        chk("to_restart", sys_status, 4);
        ticks(1);
        chk("to_expire", sys_status, 1);
        key(4'b0001);
        key(4'b0010);
        key(4'b0001);
        key(4'b0001);
        chk("asel_retained", alarm_sel, 1);
        key(4'b1000);
        chk("alarmtuning", sys_status, 5);
        key(4'b0100);
        chk("atune_inc", tune_inc, 1);
        key(4'b0001);
        chk("atune_back", sys_status, 4);
        key(4'b0001);
        chk("asel_norm", sys_status, 1);

        key(4'b1000);
        alarm(2'b10);
        key(4'b0001);
        cyc();
        chk("ring1b_idx", ring_idx, 1);
        chk("ring1b_state", sys_status, 6);
        key(4'b0100);
        chk("up_norm", sys_status, 1);
        chk("up_ring_off", ring, 0);
`ifdef SYS_MODE_SNOOZE_EN
        ticks(299);
        chk("snz_299", pending, 0);
        ticks(1);
        chk("snz_pend", pending, 2'b10);
        cyc();
        chk("snz_ring", sys_status, 6);
        chk("snz_idx", ring_idx, 1);
`else
        ticks(300);
        chk("nosnz_pend", pending, 0);
        chk("nosnz_state", sys_status, 1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
